// File: rtl/seq_alu_pkg.sv
// Shared opcode map, FSM state encoding and arithmetic helper for the sequential ALU.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;
    localparam logic [3:0] OP_POW = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Callers size-cast the result down to their own width; operands up to 64 bits.
    function automatic logic [63:0] mul_trunc(input logic [63:0] a, input logic [63:0] b);
        return a * b;
    endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative datapath for divide, modulo and power: one bit per cycle over WIDTH cycles.
module seq_alu_iter
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] res_o
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             run_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       op_q;
    // acc: remainder (div/mod) or running product (pow); sh: dividend/quotient or exponent
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] prod_acc, prod_sq;

    assign prod_acc = WIDTH'(mul_trunc(64'(acc_q), 64'(opnd_q)));
    assign prod_sq  = WIDTH'(mul_trunc(64'(opnd_q), 64'(opnd_q)));

    always_comb begin
        acc_d  = acc_q;
        sh_d   = sh_q;
        opnd_d = opnd_q;
        trial  = '0;
        if (op_q == OP_POW) begin
            if (sh_q[0]) begin
                acc_d = prod_acc;
            end
            opnd_d = prod_sq;
            sh_d   = sh_q >> 1;
        end else begin
            trial = {acc_q, sh_q[WIDTH-1]};
            if (trial >= {1'b0, opnd_q}) begin
                acc_d = WIDTH'(trial - {1'b0, opnd_q});
                sh_d  = {sh_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = trial[WIDTH-1:0];
                sh_d  = {sh_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Result reflects the final iteration so the top can latch it on the done edge.
    assign done_o = run_q && (cnt_q == '0);
    assign res_o  = (op_q == OP_DIV) ? sh_d : acc_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else if (start_i) begin
            run_q <= 1'b1;
            cnt_q <= CNT_W'(WIDTH - 1);
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start_i) begin
            op_q <= op_i;
            if (op_i == OP_POW) begin
                acc_q  <= WIDTH'(1);
                sh_q   <= b_i;
                opnd_q <= a_i;
            end else begin
                acc_q  <= '0;
                sh_q   <= a_i;
                opnd_q <= b_i;
            end
        end else if (run_q) begin
            acc_q  <= acc_d;
            sh_q   <= sh_d;
            opnd_q <= opnd_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshake: single-cycle ops resolve at accept,
// div/mod/pow run in seq_alu_iter.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [3:0]       oper,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             zero,
    output logic             err
);
    localparam logic [WIDTH:0] SHIFT_LIM = (WIDTH + 1)'(WIDTH);

    state_t           state_q;
    logic             in_ready_q, out_valid_q, carry_q, zero_q, err_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] alu_y_d;
    logic             alu_c_d, alu_err_d;
    logic [WIDTH:0]   wide;
    logic             accept, iter_start, iter_done;
    logic [WIDTH-1:0] iter_res;

    assign accept     = in_valid && in_ready_q;
    assign iter_start = accept && ((oper == OP_POW) ||
                        (((oper == OP_DIV) || (oper == OP_MOD)) && (in2 != '0)));

    seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (iter_start),
        .op_i    (oper),
        .a_i     (in1),
        .b_i     (in2),
        .done_o  (iter_done),
        .res_o   (iter_res)
    );

    // Div/mod entries here only matter for the divide-by-zero case.
    always_comb begin
        alu_y_d   = '0;
        alu_c_d   = 1'b0;
        alu_err_d = 1'b0;
        wide      = '0;
        case (oper)
            OP_ADD: begin
                wide    = {1'b0, in1} + {1'b0, in2};
                alu_y_d = wide[WIDTH-1:0];
                alu_c_d = wide[WIDTH];
            end
            OP_SUB: begin
                wide    = {1'b0, in1} - {1'b0, in2};
                alu_y_d = wide[WIDTH-1:0];
                alu_c_d = wide[WIDTH];
            end
            OP_MUL: alu_y_d = WIDTH'(mul_trunc(64'(in1), 64'(in2)));
            OP_DIV: begin
                alu_y_d   = '1;
                alu_err_d = 1'b1;
            end
            OP_MOD: begin
                alu_y_d   = in1;
                alu_err_d = 1'b1;
            end
            OP_POW: alu_y_d = '0;
            OP_SHL: alu_y_d = ({1'b0, in2} >= SHIFT_LIM) ? '0 : (in1 << in2);
            OP_SHR: alu_y_d = ({1'b0, in2} >= SHIFT_LIM) ? '0 : (in1 >> in2);
            default: alu_err_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    in_ready_q <= 1'b0;
                    if (iter_start) begin
                        state_q <= BUSY;
                    end else begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        y_q         <= alu_y_d;
                        carry_q     <= alu_c_d;
                        zero_q      <= (alu_y_d == '0);
                        err_q       <= alu_err_d;
                    end
                end
                BUSY: if (iter_done) begin
                    state_q     <= DONE;
                    out_valid_q <= 1'b1;
                    y_q         <= iter_res;
                    carry_q     <= 1'b0;
                    zero_q      <= (iter_res == '0);
                    err_q       <= 1'b0;
                end
                DONE: if (out_ready) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign err       = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=8 and WIDTH=16 with hand-computed expectations.
module tb_seq_alu;
    logic        clk = 1'b0;
    logic        rst_n;
    int          checks = 0;
    int          errors = 0;

    logic        iv8, ir8, ov8, or8, c8, z8, e8;
    logic [7:0]  a8, b8, y8;
    logic [3:0]  op8;
    logic        iv16, ir16, ov16, or16, c16, z16, e16;
    logic [15:0] a16, b16, y16;
    logic [3:0]  op16;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in1(a8), .in2(b8),
        .oper(op8), .out_valid(ov8), .out_ready(or8), .y(y8), .carry(c8), .zero(z8), .err(e8)
    );

    seq_alu #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .in1(a16), .in2(b16),
        .oper(op16), .out_valid(ov16), .out_ready(or16), .y(y16), .carry(c16), .zero(z16), .err(e16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] flags_of(input int w);
        return (w == 8) ? {ir8, c8, z8, e8} : {ir16, c16, z16, e16};
    endfunction

    // Issues one op with out_ready high, measures accept-to-out_valid latency, checks result.
    task automatic run_op(input int w, input string tag, input logic [3:0] op,
                          input logic [15:0] a, input logic [15:0] b, input logic [15:0] ey,
                          input logic ec, input logic ez, input logic ee, input int elat);
        int lat;
        logic [3:0] f;
        @(negedge clk);
        check({tag, " ready"}, (w == 8) ? ir8 : ir16, 1'b1);
        if (w == 8) begin
            iv8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            iv16 = 1'b1; op16 = op; a16 = a; b16 = b;
        end
        @(posedge clk);
        @(negedge clk);
        iv8  = 1'b0;
        iv16 = 1'b0;
        lat  = 1;
        while (!((w == 8) ? ov8 : ov16) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        f = flags_of(w);
        check({tag, " lat"}, lat, elat);
        check({tag, " y"}, (w == 8) ? {8'd0, y8} : y16, ey);
        check({tag, " flags"}, {f[3], f[2], f[1], f[0]}, {1'b0, ec, ez, ee});
    endtask

    initial begin
        int stale;
        rst_n = 1'b0;
        iv8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; or8 = 1'b1;
        iv16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; or16 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst8 state", {ir8, ov8, c8, z8, e8}, 5'b10000);
        check("rst8 y", y8, 0);
        check("rst16 state", {ir16, ov16, c16, z16, e16}, 5'b10000);
        check("rst16 y", y16, 0);
        rst_n = 1'b1;

        // add/sub, carry and borrow, zero flag
        run_op(8, "add 200+100", 4'd0, 200, 100, 44, 1'b1, 1'b0, 1'b0, 1);
        run_op(8, "sub 5-9", 4'd1, 5, 9, 252, 1'b1, 1'b0, 1'b0, 1);
        run_op(8, "add 0+0", 4'd0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1);
        run_op(8, "sub 9-5", 4'd1, 9, 5, 4, 1'b0, 1'b0, 1'b0, 1);

        // reset during BUSY discards the in-flight divide
        @(negedge clk);
        iv8 = 1'b1; op8 = 4'd3; a8 = 8'd200; b8 = 8'd7;
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst ready/valid", {ir8, ov8}, 2'b10);
        check("midrst y", y8, 0);
        check("midrst flags", {c8, z8, e8}, 3'b000);
        rst_n = 1'b1;
        stale = 0;
        repeat (12) begin
            @(negedge clk);
            if (ov8) stale++;
        end
        check("midrst stale", stale, 0);

        // iterative div/mod and divide-by-zero shortcuts
        run_op(8, "div 200/7", 4'd3, 200, 7, 28, 1'b0, 1'b0, 1'b0, 9);
        run_op(8, "mod 200/7", 4'd4, 200, 7, 4, 1'b0, 1'b0, 1'b0, 9);
        run_op(8, "div 13/0", 4'd3, 13, 0, 255, 1'b0, 1'b0, 1'b1, 1);
        run_op(8, "mod 13/0", 4'd4, 13, 0, 13, 1'b0, 1'b0, 1'b1, 1);
        run_op(8, "div 255/1", 4'd3, 255, 1, 255, 1'b0, 1'b0, 1'b0, 9);

        // power
        run_op(8, "pow 3^5", 4'd5, 3, 5, 243, 1'b0, 1'b0, 1'b0, 9);
        run_op(8, "pow 3^6", 4'd5, 3, 6, 217, 1'b0, 1'b0, 1'b0, 9);
        run_op(8, "pow 0^0", 4'd5, 0, 0, 1, 1'b0, 1'b0, 1'b0, 9);
        run_op(8, "pow 2^8", 4'd5, 2, 8, 0, 1'b0, 1'b1, 1'b0, 9);

        // 8-bit mul/shift and boundaries
        run_op(8, "mul 20*13", 4'd2, 20, 13, 4, 1'b0, 1'b0, 1'b0, 1);
        run_op(8, "shr 128>>3", 4'd7, 128, 3, 16, 1'b0, 1'b0, 1'b0, 1);
        run_op(8, "shl 1<<8", 4'd6, 1, 8, 0, 1'b0, 1'b1, 1'b0, 1);
        run_op(8, "shl 3<<7", 4'd6, 3, 7, 128, 1'b0, 1'b0, 1'b0, 1);

        // WIDTH=16
        run_op(16, "w16 mul 300*300", 4'd2, 300, 300, 24464, 1'b0, 1'b0, 1'b0, 1);
        run_op(16, "w16 shl 1<<16", 4'd6, 1, 16, 0, 1'b0, 1'b1, 1'b0, 1);
        run_op(16, "w16 shr 8000h>>15", 4'd7, 16'h8000, 15, 1, 1'b0, 1'b0, 1'b0, 1);
        run_op(16, "w16 op9", 4'd9, 1234, 5, 0, 1'b0, 1'b1, 1'b1, 1);
        run_op(16, "w16 div 1000/7", 4'd3, 1000, 7, 142, 1'b0, 1'b0, 1'b0, 17);
        run_op(16, "w16 sub 0-1", 4'd1, 0, 1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1);

        // backpressure: result held, new request ignored until handoff
        or8 = 1'b0;
        run_op(8, "bp add 10+20", 4'd0, 10, 20, 30, 1'b0, 1'b0, 1'b0, 1);
        iv8 = 1'b1; op8 = 4'd1; a8 = 8'd1; b8 = 8'd2;
        repeat (5) begin
            @(negedge clk);
            check("bp hold", {ov8, ir8, y8, c8, z8, e8}, {1'b1, 1'b0, 8'd30, 3'b000});
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        @(negedge clk);
        check("bp handoff", {ov8, ir8}, 2'b01);
        stale = 0;
        repeat (4) begin
            @(negedge clk);
            if (ov8 || !ir8) stale++;
        end
        check("bp ignored", stale, 0);
        run_op(8, "bp after add 7+8", 4'd0, 7, 8, 15, 1'b0, 1'b0, 1'b0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
